// File: rtl/iotdf_sched.sv
// Round-robin scheduler sharing one IOT data-filter datapath between N channels.
// Grants rounds of BLK_ROUND blocks, streams each block MSB byte first, tags results.
module iotdf_sched #(
    parameter int N         = 4,
    parameter int BLK_ROUND = 8,
    parameter int WAIT_MAX  = 31,
    localparam int CW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ch_req,
    input  logic [N*128-1:0] ch_data,
    input  logic [N*3-1:0]   ch_fn,
    output logic [N-1:0]     ch_ack,
    output logic             dp_rst,
    output logic [2:0]       dp_fn_sel,
    output logic             dp_in_en,
    output logic [7:0]       dp_iot_in,
    input  logic             dp_busy,
    input  logic             dp_valid,
    input  logic [127:0]     dp_out,
    output logic             res_valid,
    output logic [127:0]     res_data,
    output logic [CW-1:0]    res_ch,
    output logic [2:0]       res_fn,
    output logic [CW-1:0]    cur_ch,
    output logic             round_done,
    output logic             err_timeout
);

    localparam int BW = $clog2(BLK_ROUND + 1);
    localparam int WW = $clog2(WAIT_MAX + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        DP_RST,
        LOAD,
        STREAM,
        WAIT_DP
    } state_t;

    state_t         state;
    logic [127:0]   shift;
    logic [3:0]     byte_cnt;
    logic [BW-1:0]  blk_cnt;
    logic [WW-1:0]  wcnt;
    logic           busy_seen;
    logic           first;
    logic           have_prev;
    logic [CW-1:0]  rr;

    logic [N-1:0]   elig;
    logic           found;
    logic [CW-1:0]  win;
    logic [2:0]     fn_new;
    logic [127:0]   cur_data;
    logic           req_cur;
    logic [N-1:0]   ack_vec;
    logic           fell;
    logic           tmo;
    logic [CW-1:0]  rr_next;

    always_comb begin
        for (int i = 0; i < N; i++)
            elig[i] = ch_req[i] && (ch_fn[3*i +: 3] != 3'd0);
    end

    // first eligible channel at or after the rr pointer, wrapping
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr) + k) % N;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
    end

    always_comb begin
        cur_data = '0;
        req_cur  = 1'b0;
        fn_new   = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == cur_ch) begin
                cur_data = ch_data[128*i +: 128];
                req_cur  = ch_req[i];
            end
            if (CW'(i) == win)
                fn_new = ch_fn[3*i +: 3];
        end
    end

    assign ack_vec = {{(N-1){1'b0}}, 1'b1} << cur_ch;
    assign fell    = busy_seen && !dp_busy;
    assign tmo     = (wcnt == WW'(WAIT_MAX));
    assign rr_next = (cur_ch == CW'(N - 1)) ? '0 : cur_ch + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            byte_cnt    <= '0;
            blk_cnt     <= '0;
            wcnt        <= '0;
            busy_seen   <= 1'b0;
            first       <= 1'b1;
            have_prev   <= 1'b0;
            rr          <= '0;
            ch_ack      <= '0;
            dp_rst      <= 1'b0;
            dp_fn_sel   <= '0;
            dp_in_en    <= 1'b0;
            dp_iot_in   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_ch      <= '0;
            res_fn      <= '0;
            cur_ch      <= '0;
            round_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ch_ack     <= '0;
            round_done <= 1'b0;
            res_valid  <= 1'b0;
            dp_rst     <= first;
            first      <= 1'b0;

            if (dp_valid && state != DP_RST) begin
                res_valid <= 1'b1;
                res_data  <= dp_out;
                res_ch    <= cur_ch;
                res_fn    <= dp_fn_sel;
            end

            unique case (state)
                IDLE: begin
                    if (found) begin
                        cur_ch  <= win;
                        blk_cnt <= '0;
                        // same channel and function keeps datapath history
                        if (have_prev && win == cur_ch && fn_new == dp_fn_sel) begin
                            state <= LOAD;
                        end else begin
                            dp_fn_sel <= fn_new;
                            state     <= DP_RST;
                        end
                    end
                end
                DP_RST: begin
                    dp_rst <= 1'b1;
                    state  <= LOAD;
                end
                LOAD: begin
                    if (req_cur) begin
                        ch_ack    <= ack_vec;
                        shift     <= {cur_data[119:0], 8'h00};
                        dp_iot_in <= cur_data[127:120];
                        dp_in_en  <= 1'b1;
                        byte_cnt  <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (byte_cnt == 4'd15) begin
                        dp_in_en  <= 1'b0;
                        blk_cnt   <= blk_cnt + BW'(1);
                        wcnt      <= '0;
                        busy_seen <= 1'b0;
                        state     <= WAIT_DP;
                    end else begin
                        byte_cnt  <= byte_cnt + 4'd1;
                        dp_iot_in <= shift[127:120];
                        shift     <= {shift[119:0], 8'h00};
                    end
                end
                WAIT_DP: begin
                    wcnt <= wcnt + WW'(1);
                    if (dp_busy)
                        busy_seen <= 1'b1;
                    if (fell || tmo) begin
                        if (!fell)
                            err_timeout <= 1'b1;
                        if (blk_cnt == BW'(BLK_ROUND)) begin
                            round_done <= 1'b1;
                            rr         <= rr_next;
                            have_prev  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iotdf_sched.sv
// Directed bench for iotdf_sched with a small behavioural datapath model.
module tb_iotdf_sched;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     ch_req;
    logic [N*128-1:0] ch_data;
    logic [N*3-1:0]   ch_fn;
    logic [N-1:0]     ch_ack;
    logic             dp_rst;
    logic [2:0]       dp_fn_sel;
    logic             dp_in_en;
    logic [7:0]       dp_iot_in;
    logic             dp_busy;
    logic             dp_valid;
    logic [127:0]     dp_out;
    logic             res_valid;
    logic [127:0]     res_data;
    logic [1:0]       res_ch;
    logic [2:0]       res_fn;
    logic [1:0]       cur_ch;
    logic             round_done;
    logic             err_timeout;

    always #5 clk = ~clk;

    iotdf_sched #(.N(N), .BLK_ROUND(8), .WAIT_MAX(31)) dut (
        .clk(clk), .rst(rst),
        .ch_req(ch_req), .ch_data(ch_data), .ch_fn(ch_fn), .ch_ack(ch_ack),
        .dp_rst(dp_rst), .dp_fn_sel(dp_fn_sel), .dp_in_en(dp_in_en),
        .dp_iot_in(dp_iot_in), .dp_busy(dp_busy), .dp_valid(dp_valid),
        .dp_out(dp_out), .res_valid(res_valid), .res_data(res_data),
        .res_ch(res_ch), .res_fn(res_fn), .cur_ch(cur_ch),
        .round_done(round_done), .err_timeout(err_timeout)
    );

    int         npass = 0;
    int         ntot  = 0;
    logic [N-1:0] req_on;
    int         lim [N];
    int         acks [N];
    logic [2:0] fn_r [N];
    int         last_ack;
    int         ndprst, nres, nrd;
    logic [127:0] res_q [$];
    logic [1:0] rd_q [$];
    logic [1:0] lres_ch;
    logic [2:0] lres_fn;
    logic [7:0] bytes_q [$];
    int         bcnt, busy_cnt, dpblk;
    logic       busy_off;

    // block b: byte j (j=15 is MSB) = {b[3:0], j[3:0]}
    function automatic logic [127:0] mkblk(input int b);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++)
            r[8*j +: 8] = 8'(((b & 15) << 4) | j);
        return r;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_ch
        assign ch_req[g]           = req_on[g] && (acks[g] < lim[g]);
        assign ch_data[128*g +: 128] = mkblk(acks[g] + 1);
        assign ch_fn[3*g +: 3]     = fn_r[g];
    end

    // datapath model: busy 4 cycles after each 16th byte, result every 8 blocks since dp_rst
    always @(negedge clk) begin
        dp_valid = 1'b0;
        if (rst) begin
            bcnt = 0; busy_cnt = 0; dpblk = 0;
            dp_busy = 1'b0; dp_out = '0;
        end else begin
            if (dp_rst) dpblk = 0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0 && dpblk % 8 == 0) begin
                    dp_valid = 1'b1;
                    dp_out   = 128'(dpblk);
                end
            end
            if (dp_in_en) begin
                bytes_q.push_back(dp_iot_in);
                bcnt++;
                if (bcnt == 16) begin
                    bcnt = 0;
                    dpblk++;
                    if (!busy_off) busy_cnt = 4;
                end
            end
            dp_busy = (busy_cnt > 0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N; c++)
                if (ch_ack[c]) begin
                    acks[c]++;
                    last_ack = c;
                end
            if (dp_rst) ndprst++;
            if (res_valid) begin
                nres++;
                res_q.push_back(res_data);
                lres_ch = res_ch;
                lres_fn = res_fn;
            end
            if (round_done) begin
                nrd++;
                rd_q.push_back(cur_ch);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic wait_rd(input int target);
        int cyc = 0;
        while (nrd < target && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        chk("round wait", 128'(nrd >= target), 1);
    endtask

    int b_rst, b_rd, b_res, b_a0, b_a1, b_a2, b_a3, nbad, cyc;
    logic [7:0] e8;

    initial begin
        req_on = '0;
        busy_off = 1'b0;
        last_ack = -1;
        ndprst = 0; nres = 0; nrd = 0;
        for (int i = 0; i < N; i++) begin
            fn_r[i] = 3'd0; lim[i] = 0; acks[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst dp_rst", dp_rst, 0);
        chk("rst ch_ack", ch_ack, 0);
        chk("rst flags", {dp_in_en, res_valid, round_done, err_timeout}, 0);
        chk("rst cur_ch", cur_ch, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel dp_rst on", dp_rst, 1);
        @(negedge clk);
        chk("rel dp_rst off", dp_rst, 0);

        // 1: ch0 fn1, 8 blocks
        b_rst = ndprst; b_rd = nrd; b_res = nres;
        fn_r[0] = 3'd1; lim[0] = 8; req_on = 4'b0001;
        wait_rd(b_rd + 1);
        repeat (5) @(posedge clk);
        req_on = '0;
        chk("t1 acks", acks[0], 8);
        chk("t1 dp_rst", ndprst - b_rst, 1);
        chk("t1 nbytes", bytes_q.size(), 128);
        nbad = 0;
        for (int k = 0; k < 128 && k < bytes_q.size(); k++) begin
            e8 = 8'((((k / 16 + 1) & 15) << 4) | (15 - k % 16));
            if (bytes_q[k] !== e8) nbad++;
        end
        chk("t1 byte order", nbad, 0);
        chk("t1 first byte", bytes_q[0], 8'h1F);
        chk("t1 res count", nres - b_res, 1);
        chk("t1 res_ch", lres_ch, 0);
        chk("t1 res_fn", lres_fn, 1);
        chk("t1 res_data", res_q[res_q.size()-1], 8);
        chk("t1 rounds", nrd - b_rd, 1);

        // 2: ch1/ch3 alternate
        b_rst = ndprst; b_rd = nrd; b_a1 = acks[1]; b_a3 = acks[3];
        fn_r[1] = 3'd3; fn_r[3] = 3'd3;
        lim[1] = acks[1] + 16; lim[3] = acks[3] + 16;
        req_on = 4'b1010;
        wait_rd(b_rd + 4);
        repeat (5) @(posedge clk);
        req_on = '0;
        chk("t2 grants", {rd_q[b_rd], rd_q[b_rd+1], rd_q[b_rd+2], rd_q[b_rd+3]}, 8'h77);
        chk("t2 dp_rst", ndprst - b_rst, 4);
        chk("t2 acks1", acks[1] - b_a1, 16);
        chk("t2 acks3", acks[3] - b_a3, 16);
        chk("t2 fn_sel", dp_fn_sel, 3);

        // 3: ch2 fn6, two rounds, history kept
        b_rst = ndprst; b_rd = nrd; b_res = nres;
        fn_r[2] = 3'd6; lim[2] = acks[2] + 16; req_on = 4'b0100;
        wait_rd(b_rd + 2);
        repeat (5) @(posedge clk);
        req_on = '0;
        chk("t3 dp_rst", ndprst - b_rst, 1);
        chk("t3 res count", nres - b_res, 2);
        chk("t3 res first", res_q[res_q.size()-2], 8);
        chk("t3 res hist", res_q[res_q.size()-1], 16);
        chk("t3 res tag", {lres_ch, lres_fn}, {2'd2, 3'd6});

        // 4: ch0 disabled, ch1 fn4
        b_rd = nrd; b_a0 = acks[0]; b_a1 = acks[1];
        fn_r[0] = 3'd0; fn_r[1] = 3'd4;
        lim[0] = acks[0] + 100; lim[1] = acks[1] + 8;
        req_on = 4'b0011;
        wait_rd(b_rd + 1);
        repeat (5) @(posedge clk);
        req_on = '0;
        chk("t4 ch0 acks", acks[0] - b_a0, 0);
        chk("t4 ch1 acks", acks[1] - b_a1, 8);
        chk("t4 res tag", {lres_ch, lres_fn}, {2'd1, 3'd4});

        // 5: busy never rises
        chk("t5 err pre", err_timeout, 0);
        b_a2 = acks[2];
        fn_r[2] = 3'd2; lim[2] = acks[2] + 2; busy_off = 1'b1;
        req_on = 4'b0100;
        @(negedge clk);
        cyc = 0;
        while (!dp_in_en && cyc < 200) begin @(negedge clk); cyc++; end
        chk("t5 stream start", dp_in_en, 1);
        cyc = 0;
        while (dp_in_en && cyc < 40) begin @(negedge clk); cyc++; end
        chk("t5 stream end", dp_in_en, 0);
        repeat (31) @(negedge clk);
        chk("t5 err early", err_timeout, 0);
        @(negedge clk);
        chk("t5 err set", err_timeout, 1);
        cyc = 0;
        while (acks[2] != b_a2 + 2 && cyc < 200) begin @(posedge clk); cyc++; end
        chk("t5 next load", acks[2] - b_a2, 2);
        chk("t5 err sticky", err_timeout, 1);

        // 6: reset mid-block
        rst = 1'b1;
        repeat (2) @(negedge clk);
        req_on = '0; busy_off = 1'b0;
        rst = 1'b0;
        b_a1 = acks[1];
        fn_r[1] = 3'd5; lim[1] = acks[1] + 8; req_on = 4'b0010;
        cyc = 0;
        while (!(acks[1] == b_a1 + 3 && bcnt >= 8) && cyc < 500) begin
            @(posedge clk); cyc++;
        end
        chk("t6 mid block", 128'(acks[1] == b_a1 + 3 && bcnt >= 8), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6 dp_in_en", dp_in_en, 0);
        chk("t6 ch_ack", ch_ack, 0);
        chk("t6 err clr", err_timeout, 0);
        chk("t6 cur_ch", cur_ch, 0);
        b_a0 = acks[0];
        fn_r[0] = 3'd1; lim[0] = acks[0] + 1; req_on = 4'b0011;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        while (acks[0] == b_a0 && acks[1] == b_a1 + 3 && cyc < 200) begin
            @(posedge clk); cyc++;
        end
        chk("t6 next grant", last_ack, 0);
        chk("t6 no replay", acks[1] - b_a1, 3);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
